prog_loader: RTL and testbench

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/prog_loader_pkg.sv | 16 +
 rtl/prog_loader_word_assembler.sv | 38 +++
 rtl/prog_loader.sv | 172 +++++++++++++++++
 tb/tb_prog_loader.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/prog_loader_pkg.sv
// Shared types and parameter defaults for the program loader.
package prog_loader_pkg;

    typedef enum logic [2:0] {
        ST_LEN_LO = 3'd0,
        ST_LEN_HI = 3'd1,
        ST_BYTE   = 3'd2,
        ST_WRITE  = 3'd3,
        ST_DONE   = 3'd4,
        ST_ERR    = 3'd5
    } state_t;

    localparam logic [31:0] DEF_BASE_ADDR = 32'h0000_0000;
    localparam int unsigned DEF_MAX_WORDS = 256;

endpackage

// File: rtl/prog_loader_word_assembler.sv
// Collects four bytes into one 32-bit word, one lane per accepted byte.
// word_o already includes a byte being loaded this cycle, so the loader
// can capture a complete word on the same edge as the fourth byte.
module word_assembler (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  byte_i,
    input  logic [1:0]  lane_i,
    input  logic        load_i,
    input  logic        clear_i,
    output logic [31:0] word_o
);

    logic [31:0] word_q;
    logic [31:0] word_d;

    // Next word: clear wins over load; load replaces the selected lane.
    always_comb begin
        word_d = word_q;
        if (clear_i) begin
            word_d = 32'd0;
        end else if (load_i) begin
            word_d[8*lane_i +: 8] = byte_i;
        end
    end

    // Assembly register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            word_q <= 32'd0;
        end else begin
            word_q <= word_d;
        end
    end

    assign word_o = word_d;

endmodule

// File: rtl/prog_loader.sv
// Streams a length-prefixed program into instruction memory while holding
// the core in reset, then releases it.
//
// state     | meaning
// ----------+-----------------------------------------------
// LEN_LO    | waiting for word count low byte
// LEN_HI    | waiting for word count high byte
// BYTE      | collecting the 4 bytes of the current word
// WRITE     | one-cycle instruction memory write
// DONE      | program loaded, core released
// ERR       | declared length too large, core held
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = DEF_BASE_ADDR,
    parameter int unsigned MAX_WORDS = DEF_MAX_WORDS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    input  logic        start,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        cpu_rst,
    output logic        done,
    output logic        err
);

    state_t      state_q, state_d;
    logic [15:0] n_q, n_d;
    logic [15:0] index_q, index_d;
    logic [1:0]  bcnt_q, bcnt_d;
    logic        imem_we_q, imem_we_d;
    logic [31:0] imem_addr_q, imem_addr_d;
    logic [31:0] imem_wdata_q, imem_wdata_d;
    logic        cpu_rst_q, cpu_rst_d;
    logic        done_q, done_d;
    logic        err_q, err_d;

    logic        fire;
    logic        asm_load;
    logic        asm_clear;
    logic [15:0] n_full;
    logic [31:0] asm_word;

    assign in_ready = (state_q == ST_LEN_LO) || (state_q == ST_LEN_HI) ||
                      (state_q == ST_BYTE);
    assign fire     = in_valid && in_ready;
    assign n_full   = {in_data, n_q[7:0]};

    word_assembler u_asm (
        .clk     (clk),
        .rst     (rst),
        .byte_i  (in_data),
        .lane_i  (bcnt_q),
        .load_i  (asm_load),
        .clear_i (asm_clear),
        .word_o  (asm_word)
    );

    // Next-state logic; outputs are registered from the next state so they
    // line up with the state they describe.
    always_comb begin
        state_d   = state_q;
        n_d       = n_q;
        index_d   = index_q;
        bcnt_d    = bcnt_q;
        asm_load  = 1'b0;
        asm_clear = 1'b0;

        case (state_q)
            ST_LEN_LO: begin
                if (fire) begin
                    n_d[7:0] = in_data;
                    state_d  = ST_LEN_HI;
                end
            end
            ST_LEN_HI: begin
                if (fire) begin
                    n_d[15:8] = in_data;
                    if (n_full == 16'd0) begin
                        state_d = ST_DONE;
                    end else if (32'(n_full) > MAX_WORDS) begin
                        state_d = ST_ERR;
                    end else begin
                        state_d   = ST_BYTE;
                        index_d   = 16'd0;
                        bcnt_d    = 2'd0;
                        asm_clear = 1'b1;
                    end
                end
            end
            ST_BYTE: begin
                if (fire) begin
                    asm_load = 1'b1;
                    bcnt_d   = bcnt_q + 2'd1;
                    if (bcnt_q == 2'd3) begin
                        state_d = ST_WRITE;
                    end
                end
            end
            ST_WRITE: begin
                if (({1'b0, index_q} + 17'd1) == {1'b0, n_q}) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_BYTE;
                    index_d = index_q + 16'd1;
                    bcnt_d  = 2'd0;
                end
            end
            ST_DONE, ST_ERR: begin
                if (start) begin
                    state_d   = ST_LEN_LO;
                    n_d       = 16'd0;
                    index_d   = 16'd0;
                    bcnt_d    = 2'd0;
                    asm_clear = 1'b1;
                end
            end
            default: state_d = ST_LEN_LO;
        endcase

        imem_we_d    = (state_d == ST_WRITE);
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;
        if (state_d == ST_WRITE) begin
            imem_addr_d  = BASE_ADDR + {14'd0, index_q, 2'b00};
            imem_wdata_d = asm_word;
        end
        cpu_rst_d = (state_d != ST_DONE);
        done_d    = (state_d == ST_DONE);
        err_d     = (state_d == ST_ERR);
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_LEN_LO;
            n_q          <= 16'd0;
            index_q      <= 16'd0;
            bcnt_q       <= 2'd0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= BASE_ADDR;
            imem_wdata_q <= 32'd0;
            cpu_rst_q    <= 1'b1;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            n_q          <= n_d;
            index_q      <= index_d;
            bcnt_q       <= bcnt_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            cpu_rst_q    <= cpu_rst_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign imem_we    = imem_we_q;
    assign imem_addr  = imem_addr_q;
    assign imem_wdata = imem_wdata_q;
    assign cpu_rst    = cpu_rst_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: drives byte streams, records memory writes.
module tb_prog_loader;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        start;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_rst;
    logic        done;
    logic        err;

    int n_vec;
    int n_miscmp;

    int          wr_cnt;
    logic [31:0] wr_addr [0:299];
    logic [31:0] wr_data [0:299];

    prog_loader #(
        .BASE_ADDR (32'h0000_0000),
        .MAX_WORDS (256)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .start      (start),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_rst    (cpu_rst),
        .done       (done),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write monitor: records every cycle the write strobe is high.
    initial wr_cnt = 0;
    always @(negedge clk) begin
        if (imem_we) begin
            if (wr_cnt < 300) begin
                wr_addr[wr_cnt] = imem_addr;
                wr_data[wr_cnt] = imem_wdata;
            end
            wr_cnt = wr_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (obs !== exp) begin
            n_miscmp = n_miscmp + 1;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Offer one byte starting at a negedge; returns at the negedge after it
    // was accepted, with in_valid low. gap adds idle cycles afterwards.
    task automatic send_byte(input logic [7:0] b, input int gap);
        bit taken;
        taken = 0;
        in_valid = 1'b1;
        in_data  = b;
        for (int i = 0; i < 20 && !taken; i++) begin
            taken = in_ready;
            @(negedge clk);
        end
        if (!taken) chk("byte_accept_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
        for (int i = 0; i < gap; i++) @(negedge clk);
    endtask

    task automatic wait_end(input int budget);
        int i;
        i = 0;
        while (!done && !err && i < budget) begin
            @(negedge clk);
            i++;
        end
        if (!done && !err) chk("end_timeout", 32'd0, 32'd1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        int base;
        bit ok;
        logic [7:0] ib;
        n_vec    = 0;
        n_miscmp = 0;
        rst      = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        start    = 1'b0;

        // Reset state
        #23;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_we", {31'd0, imem_we}, 32'd0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_wdata", imem_wdata, 32'h0);
        chk("rst_cpu_rst", {31'd0, cpu_rst}, 32'd1);
        chk("rst_done_err", {30'd0, done, err}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Two-word program, back-to-back bytes
        base = wr_cnt;
        send_byte(8'h02, 0); send_byte(8'h00, 0);
        send_byte(8'h13, 0); send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
        send_byte(8'hB3, 0); send_byte(8'h00, 0); send_byte(8'h10, 0); send_byte(8'h00, 0);
        wait_end(10);
        chk("p2_writes", 32'(wr_cnt - base), 32'd2);
        chk("p2_addr0", wr_addr[base], 32'h0);
        chk("p2_data0", wr_data[base], 32'h0000_0013);
        chk("p2_addr1", wr_addr[base+1], 32'h4);
        chk("p2_data1", wr_data[base+1], 32'h0010_00B3);
        chk("p2_done", {31'd0, done}, 32'd1);
        chk("p2_cpu_rst", {31'd0, cpu_rst}, 32'd0);
        chk("p2_in_ready", {31'd0, in_ready}, 32'd0);

        // Bytes offered in DONE are ignored
        in_valid = 1'b1; in_data = 8'h05;
        repeat (3) @(negedge clk);
        in_valid = 1'b0;
        chk("done_ignore_writes", 32'(wr_cnt - base), 32'd2);
        chk("done_hold", {30'd0, done, cpu_rst}, 32'd2);

        // start re-arms
        pulse_start();
        chk("start_cpu_rst", {31'd0, cpu_rst}, 32'd1);
        chk("start_done", {31'd0, done}, 32'd0);
        chk("start_in_ready", {31'd0, in_ready}, 32'd1);

        // Zero-length program
        base = wr_cnt;
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        chk("n0_done", {31'd0, done}, 32'd1);
        chk("n0_cpu_rst", {31'd0, cpu_rst}, 32'd0);
        chk("n0_writes", 32'(wr_cnt - base), 32'd0);
        pulse_start();

        // Length 257 exceeds MAX_WORDS
        send_byte(8'h01, 0);
        send_byte(8'h01, 0);
        chk("n257_err", {31'd0, err}, 32'd1);
        chk("n257_in_ready", {31'd0, in_ready}, 32'd0);
        chk("n257_cpu_rst", {31'd0, cpu_rst}, 32'd1);
        chk("n257_done", {31'd0, done}, 32'd0);
        pulse_start();
        chk("err_start_err", {31'd0, err}, 32'd0);
        chk("err_start_in_ready", {31'd0, in_ready}, 32'd1);

        // One word with in_valid toggling
        base = wr_cnt;
        send_byte(8'h01, 1); send_byte(8'h00, 1);
        send_byte(8'h11, 1); send_byte(8'h22, 1); send_byte(8'h33, 1); send_byte(8'h44, 1);
        wait_end(10);
        chk("tog_writes", 32'(wr_cnt - base), 32'd1);
        chk("tog_addr", wr_addr[base], 32'h0);
        chk("tog_data", wr_data[base], 32'h4433_2211);
        chk("tog_done", {31'd0, done}, 32'd1);
        pulse_start();

        // Reset mid-word abandons the load
        base = wr_cnt;
        send_byte(8'h02, 0); send_byte(8'h00, 0);
        send_byte(8'hAA, 0); send_byte(8'hBB, 0);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_cpu_rst", {31'd0, cpu_rst}, 32'd1);
        chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_writes", 32'(wr_cnt - base), 32'd0);
        send_byte(8'h01, 0); send_byte(8'h00, 0);
        send_byte(8'hAA, 0); send_byte(8'hBB, 0); send_byte(8'hCC, 0); send_byte(8'hDD, 0);
        wait_end(10);
        chk("post_rst_writes", 32'(wr_cnt - base), 32'd1);
        chk("post_rst_addr", wr_addr[base], 32'h0);
        chk("post_rst_data", wr_data[base], 32'hDDCC_BBAA);
        chk("post_rst_done", {31'd0, done}, 32'd1);
        pulse_start();

        // Largest accepted length: 256 words, word i = {i, 5A, ~i, i}
        base = wr_cnt;
        send_byte(8'h00, 0); send_byte(8'h01, 0);
        for (int i = 0; i < 256; i++) begin
            ib = 8'(i);
            send_byte(ib, 0); send_byte(~ib, 0); send_byte(8'h5A, 0); send_byte(ib, 0);
        end
        wait_end(10);
        chk("n256_writes", 32'(wr_cnt - base), 32'd256);
        ok = 1;
        for (int i = 0; i < 256; i++) begin
            ib = 8'(i);
            if (wr_addr[base+i] !== 32'(4*i) || wr_data[base+i] !== {ib, 8'h5A, ~ib, ib})
                ok = 0;
        end
        chk("n256_all_words", {31'd0, ok}, 32'd1);
        chk("n256_last_addr", wr_addr[base+255], 32'h0000_03FC);
        chk("n256_last_data", wr_data[base+255], 32'hFF5A_00FF);
        chk("n256_done", {31'd0, done}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end

endmodule
